// File: rtl/single_port_memory.sv
// Single-port synchronous RAM with a registered, read-first read port.
// A read happens every cycle outside reset. A write to the same address in
// the same cycle returns the old word. Addresses at or beyond DataDepth are
// ignored on write and read back as zero. Reset clears only the output
// register and leaves the array untouched.
module single_port_memory #(
    parameter int DataWidth = 8,
    parameter int DataDepth = 4096,
    parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [DataWidth-1:0] mem_wr_data_i,
    output logic [DataWidth-1:0] mem_rd_data_o
);

    // Depth widened by one bit so that a power-of-two depth stays representable.
    localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(DataDepth);

    // Storage; entries that are never written or preloaded stay unknown.
    logic [DataWidth-1:0] memory [DataDepth];

    logic                 addr_in_range_s;
    logic                 wr_en_s;
    logic [DataWidth-1:0] rd_data_d;
    logic [DataWidth-1:0] rd_data_q;

    // Addresses past the last word only occur when the depth is not a power of two.
    function automatic logic addr_in_range(input logic [AddrWidth-1:0] addr);
        return ({1'b0, addr} < DepthExt);
    endfunction

    assign addr_in_range_s = addr_in_range(mem_addr_i);
    assign wr_en_s         = rst_ni & mem_we_i & addr_in_range_s;

    // Write port: no reset, so the contents survive reset and preloads are kept.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            memory[mem_addr_i] <= mem_wr_data_i;
        end
    end

    // Next read word: the current (pre-write) contents, or zero when out of range.
    always_comb begin
        rd_data_d = '0;
        if (addr_in_range_s) begin
            rd_data_d = memory[mem_addr_i];
        end else begin
            rd_data_d = '0;
        end
    end

    // Read data register: cleared by synchronous reset, otherwise loaded every cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign mem_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_single_port_memory.sv
// Directed bench for single_port_memory. It uses three instances:
//   u_big : default depth 4096
//   u_mid : depth 100, for out-of-range addresses
//   u_one : depth 1
// Expected read words are pushed to a scoreboard queue when an address is
// driven. They are popped and compared one cycle later, after the rising edge.
module tb_single_port_memory;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [11:0] a_addr;
    logic        a_we;
    logic [7:0]  a_wd;
    logic [7:0]  a_rd;

    logic [6:0]  b_addr;
    logic        b_we;
    logic [7:0]  b_wd;
    logic [7:0]  b_rd;

    logic [0:0]  c_addr;
    logic        c_we;
    logic [7:0]  c_wd;
    logic [7:0]  c_rd;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        int unsigned dut;
        logic [7:0]  exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];

    single_port_memory u_big (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mem_addr_i    (a_addr),
        .mem_we_i      (a_we),
        .mem_wr_data_i (a_wd),
        .mem_rd_data_o (a_rd)
    );

    single_port_memory #(.DataWidth(8), .DataDepth(100)) u_mid (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mem_addr_i    (b_addr),
        .mem_we_i      (b_we),
        .mem_wr_data_i (b_wd),
        .mem_rd_data_o (b_rd)
    );

    single_port_memory #(.DataWidth(8), .DataDepth(1), .AddrWidth(1)) u_one (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mem_addr_i    (c_addr),
        .mem_we_i      (c_we),
        .mem_wr_data_i (c_wd),
        .mem_rd_data_o (c_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drain();
        sb_t        e;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.dut)
                0:       obs = a_rd;
                1:       obs = b_rd;
                2:       obs = c_rd;
                default: obs = 8'hxx;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    // Drive one access on the selected instance, queue its expected word, clock once, then check.
    task automatic step(input int unsigned dut, input logic [11:0] addr, input logic we,
                        input logic [7:0] wd, input logic [7:0] exp, input string tag);
        case (dut)
            0: begin a_addr = addr;      a_we = we; a_wd = wd; end
            1: begin b_addr = addr[6:0]; b_we = we; b_wd = wd; end
            2: begin c_addr = addr[0:0]; c_we = we; c_wd = wd; end
            default: ;
        endcase
        sb_q.push_back('{dut, exp, tag});
        @(posedge clk);
        #1;
        a_we = 1'b0;
        b_we = 1'b0;
        c_we = 1'b0;
        drain();
    endtask

    initial begin
        rst_n  = 1'b0;
        a_addr = 12'd0; a_we = 1'b0; a_wd = 8'h00;
        b_addr = 7'd0;  b_we = 1'b0; b_wd = 8'h00;
        c_addr = 1'd0;  c_we = 1'b0; c_wd = 8'h00;

        // Backdoor preloads before the first edge
        for (int i = 0; i < 96; i++) u_big.memory[i] = 8'(i);
        for (int i = 0; i < 100; i++) u_mid.memory[i] = 8'(i + 1);
        u_one.memory[0] = 8'h00;

        // Reset state of all instances
        sb_q.push_back('{0, 8'h00, "reset_big"});
        sb_q.push_back('{1, 8'h00, "reset_mid"});
        sb_q.push_back('{2, 8'h00, "reset_one"});
        @(posedge clk);
        #1;
        drain();
        rst_n = 1'b1;

        // Preload survival: sequential reads, 1-cycle latency
        for (int i = 0; i < 96; i++) begin
            step(0, 12'(i), 1'b0, 8'h00, 8'(i), $sformatf("preload_%0d", i));
        end

        // Write then read
        step(0, 12'd10, 1'b1, 8'hA5, 8'd10, "wr10_old");
        step(0, 12'd10, 1'b0, 8'h00, 8'hA5, "rd10_new");

        // Read-first collision
        u_big.memory[5] = 8'h11;
        step(0, 12'd5, 1'b1, 8'h22, 8'h11, "collide_old");
        step(0, 12'd5, 1'b0, 8'h00, 8'h22, "collide_new");

        // Reset mid-operation with a write attempt
        u_big.memory[3] = 8'h7F;
        step(0, 12'd3, 1'b0, 8'h00, 8'h7F, "pre_rst_rd3");
        rst_n = 1'b0;
        step(0, 12'd3, 1'b1, 8'h00, 8'h00, "rst_out_zero");
        rst_n = 1'b1;
        chk("rst_keeps_mem3", u_big.memory[3], 8'h7F);
        step(0, 12'd3, 1'b0, 8'h00, 8'h7F, "post_rst_rd3");

        // Out-of-range on depth 100
        step(1, 12'd99, 1'b0, 8'h00, 8'd100, "mid_rd99");
        step(1, 12'd120, 1'b1, 8'h55, 8'h00, "mid_wr120");
        step(1, 12'd120, 1'b0, 8'h00, 8'h00, "mid_rd120");
        step(1, 12'd100, 1'b0, 8'h00, 8'h00, "mid_rd100");
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("mid_keep_%0d", i), u_mid.memory[i], 8'(i + 1));
        end
        step(1, 12'd0, 1'b0, 8'h00, 8'h01, "mid_rd0");

        // Depth-1 instance
        step(2, 12'd0, 1'b1, 8'h3C, 8'h00, "one_wr0");
        step(2, 12'd0, 1'b0, 8'h00, 8'h3C, "one_rd0");
        step(2, 12'd1, 1'b1, 8'h99, 8'h00, "one_rd1_oor");
        step(2, 12'd0, 1'b0, 8'h00, 8'h3C, "one_rd0_kept");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
